// File: rtl/sigmoid_lut_fetch_pkg.sv
// Shared constants, stage record types and the reset-time sigmoid table for the
// sigmoid LUT fetch stage that feeds the linear interpolator.
package sigmoid_lut_fetch_pkg;

  localparam int DW        = 8;
  localparam int FRAC      = 4;
  localparam int NSEG      = 16;
  localparam int TBL_DEPTH = NSEG + 1;
  localparam int TBL_AW    = 5;
  localparam int IDX_W     = $clog2(NSEG);

  // Entry 16 sits in the top byte, entry 0 in the bottom byte.
  localparam logic [TBL_DEPTH*DW-1:0] SIGMOID_DEFAULTS = {
    8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd15, 8'd14, 8'd12, 8'd8,
    8'd4,  8'd2,  8'd1,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0
  };

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [FRAC-1:0]  rem;
  } stage1_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] base;
    logic [DW-1:0] nxt;
    logic [DW-1:0] change;
    logic [DW-1:0] remaining;
  } stage2_t;

  function automatic logic [DW-1:0] defaultEntry(input int unsigned i);
    return SIGMOID_DEFAULTS[i*DW +: DW];
  endfunction

endpackage

// File: rtl/sigmoid_lut_fetch_if.sv
// Bundle of the input handshake, the output bus toward the interpolator and the
// runtime table write port. Widths come from the shared package.
interface sigmoid_lut_fetch_if;
  import sigmoid_lut_fetch_pkg::*;

  logic signed [DW-1:0]     x;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DW-1:0]     base;
  logic signed [DW-1:0]     next__data;
  logic signed [DW-1:0]     change;
  logic        [DW-1:0]     remaining;
  logic                     out_valid;
  logic                     out_ready;
  logic                     tbl_we;
  logic        [TBL_AW-1:0] tbl_addr;
  logic signed [DW-1:0]     tbl_data;

  modport master (
    output x, in_valid, out_ready, tbl_we, tbl_addr, tbl_data,
    input  in_ready, base, next__data, change, remaining, out_valid
  );

  modport slave (
    input  x, in_valid, out_ready, tbl_we, tbl_addr, tbl_data,
    output in_ready, base, next__data, change, remaining, out_valid
  );

endinterface

// File: rtl/sigmoid_lut_fetch_table.sv
// Sigmoid breakpoint register file: DEPTH entries, one synchronous write port
// and two combinational read ports (segment start and segment end).
module sigmoid_lut_table #(
  parameter int DW    = sigmoid_lut_fetch_pkg::DW,
  parameter int DEPTH = sigmoid_lut_fetch_pkg::TBL_DEPTH,
  parameter int AW    = sigmoid_lut_fetch_pkg::TBL_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);
  import sigmoid_lut_fetch_pkg::*;

  logic [DW-1:0] mem_q [DEPTH];

  // Reset reloads the sigmoid curve and wins over a simultaneous write;
  // writes to addresses past the last entry are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= defaultEntry(i);
      end
    end else if (we_i && (waddr_i < AW'(DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/sigmoid_lut_fetch.sv
// Two-stage table fetch in front of the sigmoid interpolator. Stage 1 splits the
// Q3.4 operand into a segment index and an in-segment fraction; stage 2 reads
// the two segment endpoints, forms their difference and presents the result.
// Both stages move together whenever the output slot is free or being drained.
module sigmoid_lut_fetch #(
  parameter int DW   = sigmoid_lut_fetch_pkg::DW,
  parameter int FRAC = sigmoid_lut_fetch_pkg::FRAC,
  parameter int NSEG = sigmoid_lut_fetch_pkg::NSEG
) (
  input logic                clk,
  input logic                rst,
  sigmoid_lut_fetch_if.slave bus
);
  import sigmoid_lut_fetch_pkg::*;

  logic                advance;
  logic [IDX_W-1:0]    idxIn;
  logic [FRAC-1:0]     remIn;
  logic [TBL_AW-1:0]   rdAddrBase;
  logic [TBL_AW-1:0]   rdAddrNext;
  logic [DW-1:0]       rdBase;
  logic [DW-1:0]       rdNext;
  stage1_t             s1_q, s1_d;
  stage2_t             s2_q, s2_d;

  assign advance      = !s2_q.valid || bus.out_ready;
  assign bus.in_ready = advance;

  // (x >>> FRAC) + NSEG/2 on a signed integer part is the integer part with
  // its sign bit flipped, which keeps the index in 0..NSEG-1 without an adder.
  assign idxIn = {~bus.x[DW-1], bus.x[DW-2:FRAC]};
  assign remIn = bus.x[FRAC-1:0];

  // The table's last entry is the saturation endpoint, so idx+1 stays in range.
  assign rdAddrBase = TBL_AW'(s1_q.idx);
  assign rdAddrNext = rdAddrBase + TBL_AW'(1);

  sigmoid_lut_table #(
    .DW    (DW),
    .DEPTH (NSEG + 1),
    .AW    (TBL_AW)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .we_i      (bus.tbl_we),
    .waddr_i   (bus.tbl_addr),
    .wdata_i   (bus.tbl_data),
    .raddr_a_i (rdAddrBase),
    .rdata_a_o (rdBase),
    .raddr_b_i (rdAddrNext),
    .rdata_b_o (rdNext)
  );

  // Next-state for both stages: hold everything unless the pipe advances; an
  // idle input on an advance loads a bubble into stage 1.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (advance) begin
      s1_d.valid     = bus.in_valid;
      s1_d.idx       = idxIn;
      s1_d.rem       = remIn;
      s2_d.valid     = s1_q.valid;
      s2_d.base      = rdBase;
      s2_d.nxt       = rdNext;
      s2_d.change    = rdNext - rdBase;
      s2_d.remaining = {{(DW-FRAC){1'b0}}, s1_q.rem};
    end
  end

  // Pipeline registers; reset empties both stages and clears the output bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign bus.out_valid  = s2_q.valid;
  assign bus.base       = s2_q.base;
  assign bus.next__data = s2_q.nxt;
  assign bus.change     = s2_q.change;
  assign bus.remaining  = s2_q.remaining;

endmodule

// File: tb/tb_sigmoid_lut_fetch.sv
// Self-checking bench for sigmoid_lut_fetch: directed lookups, a randomized
// streaming run against a scoreboard, stalls, table writes and reset recovery.
module tb_sigmoid_lut_fetch;

  logic clk;
  logic rst;
  int   compareCount;
  int   failCount;
  int   tblModel [17];
  int   tblDefaults [17] = '{0, 0, 0, 0, 0, 1, 2, 4, 8, 12, 14, 15, 16, 16, 16, 16, 16};

  sigmoid_lut_fetch_if bus ();

  sigmoid_lut_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a scenario never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output record for operand xv from the table contents:
  // position counted from -8.0 in 1/16 steps, split into segment and fraction.
  function automatic logic [31:0] modelLookup(input logic [7:0] xv);
    int pos;
    int idx;
    int rem;
    int b;
    int n;
    pos = int'($signed(xv)) + 128;
    idx = pos / 16;
    rem = pos % 16;
    b   = tblModel[idx];
    n   = tblModel[idx + 1];
    return {8'(b), 8'(n), 8'(n - b), 8'(rem)};
  endfunction

  function automatic logic [32:0] snap();
    return {bus.out_valid, bus.base, bus.next__data, bus.change, bus.remaining};
  endfunction

  // Present one operand and wait until it reaches the output.
  task automatic driveLookup(input logic [7:0] xv);
    bus.x         = xv;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [33:0] got;
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x         = 8'h00;
    tick();
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tblModel     = tblDefaults;
    #1;
    got = {bus.in_ready, snap()};
    compareCount++;
    if (got !== {1'b1, 33'd0}) begin
      failCount++;
      $display("[TB] FAIL reset_state: got %h expected %h", got, {1'b1, 33'd0});
    end
  endtask

  task automatic test_lookup();
    logic [7:0]  xs   [4];
    logic [32:0] exps [4];
    xs[0] = 8'h00; exps[0] = {1'b1, 8'd8,  8'd12, 8'd4, 8'd0};
    xs[1] = 8'h18; exps[1] = {1'b1, 8'd12, 8'd14, 8'd2, 8'd8};
    xs[2] = 8'h80; exps[2] = {1'b1, 8'd0,  8'd0,  8'd0, 8'd0};
    xs[3] = 8'h7F; exps[3] = {1'b1, 8'd16, 8'd16, 8'd0, 8'd15};
    for (int i = 0; i < 4; i++) begin
      bus.x         = xs[i];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      compareCount++;
      if (bus.out_valid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL lookup_latency x=%02h: out_valid after 1 cycle got %b expected 0", xs[i], bus.out_valid);
      end
      tick();
      compareCount++;
      if (snap() !== exps[i]) begin
        failCount++;
        $display("[TB] FAIL lookup x=%02h: got %h expected %h", xs[i], snap(), exps[i]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] expQ [$];
    logic [31:0] expV;
    logic [31:0] gotV;
    for (int c = 0; c < 500; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.x         = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.tbl_we    = ($urandom_range(0, 7) == 0);
      bus.tbl_addr  = 5'($urandom_range(17, 31));
      bus.tbl_data  = 8'($urandom);
      #1;
      compareCount++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        failCount++;
        $display("[TB] FAIL rand_in_ready cycle %0d: got %b expected %b", c, bus.in_ready, (!bus.out_valid || bus.out_ready));
      end
      if (bus.out_valid && bus.out_ready) begin
        gotV = {bus.base, bus.next__data, bus.change, bus.remaining};
        compareCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL rand_spurious cycle %0d: got output %h expected none", c, gotV);
        end else begin
          expV = expQ.pop_front();
          if (gotV !== expV) begin
            failCount++;
            $display("[TB] FAIL rand_data cycle %0d: got %h expected %h", c, gotV, expV);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expQ.push_back(modelLookup(bus.x));
      end
      tick();
    end
    bus.tbl_we    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int d = 0; d < 6; d++) begin
      #1;
      if (bus.out_valid) begin
        gotV = {bus.base, bus.next__data, bus.change, bus.remaining};
        compareCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL rand_drain_spurious: got output %h expected none", gotV);
        end else begin
          expV = expQ.pop_front();
          if (gotV !== expV) begin
            failCount++;
            $display("[TB] FAIL rand_drain_data: got %h expected %h", gotV, expV);
          end
        end
      end
      tick();
    end
    compareCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL rand_lost: got %0d samples still owed expected 0", expQ.size());
    end
  endtask

  task automatic test_stall();
    logic [7:0] emitted [3];
    int         nEmit;
    nEmit         = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.x         = 8'h00;
    tick();
    bus.x = 8'h10;
    tick();
    bus.x         = 8'h20;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      compareCount++;
      if ({bus.in_ready, snap()} !== {1'b0, 1'b1, 8'd8, 8'd12, 8'd4, 8'd0}) begin
        failCount++;
        $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h", k, {bus.in_ready, snap()}, {1'b0, 1'b1, 8'd8, 8'd12, 8'd4, 8'd0});
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (nEmit < 3) emitted[nEmit] = bus.base;
        nEmit++;
      end
      tick();
      bus.in_valid = 1'b0;
    end
    compareCount++;
    if (nEmit != 3) begin
      failCount++;
      $display("[TB] FAIL stall_count: got %0d outputs expected 3", nEmit);
    end else begin
      compareCount++;
      if ({emitted[0], emitted[1], emitted[2]} !== {8'd8, 8'd12, 8'd14}) begin
        failCount++;
        $display("[TB] FAIL stall_order: got %h expected %h", {emitted[0], emitted[1], emitted[2]}, {8'd8, 8'd12, 8'd14});
      end
    end
  endtask

  task automatic test_table_write();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 5'd8;
    bus.tbl_data  = 8'd10;
    tick();
    bus.tbl_we  = 1'b0;
    tblModel[8] = 10;
    driveLookup(8'h00);
    compareCount++;
    if (snap() !== {1'b1, 8'd10, 8'd12, 8'd2, 8'd0}) begin
      failCount++;
      $display("[TB] FAIL write_new: got %h expected %h", snap(), {1'b1, 8'd10, 8'd12, 8'd2, 8'd0});
    end
    bus.x        = 8'h00;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 5'd8;
    bus.tbl_data = 8'd9;
    tick();
    bus.tbl_we  = 1'b0;
    tblModel[8] = 9;
    compareCount++;
    if (snap() !== {1'b1, 8'd10, 8'd12, 8'd2, 8'd0}) begin
      failCount++;
      $display("[TB] FAIL write_same_cycle_old: got %h expected %h", snap(), {1'b1, 8'd10, 8'd12, 8'd2, 8'd0});
    end
    driveLookup(8'h00);
    compareCount++;
    if (snap() !== {1'b1, 8'd9, 8'd12, 8'd3, 8'd0}) begin
      failCount++;
      $display("[TB] FAIL write_next_cycle_new: got %h expected %h", snap(), {1'b1, 8'd9, 8'd12, 8'd3, 8'd0});
    end
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 5'd20;
    bus.tbl_data = 8'h55;
    tick();
    bus.tbl_we = 1'b0;
    driveLookup(8'hC0);
    compareCount++;
    if (snap() !== {1'b1, modelLookup(8'hC0)}) begin
      failCount++;
      $display("[TB] FAIL write_ignored_idx4: got %h expected %h", snap(), {1'b1, modelLookup(8'hC0)});
    end
    driveLookup(8'h00);
    compareCount++;
    if (snap() !== {1'b1, 8'd9, 8'd12, 8'd3, 8'd0}) begin
      failCount++;
      $display("[TB] FAIL write_ignored_idx8: got %h expected %h", snap(), {1'b1, 8'd9, 8'd12, 8'd3, 8'd0});
    end
  endtask

  task automatic test_reset_midstream();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x         = 8'h10;
    tick();
    bus.x = 8'h20;
    tick();
    rst          = 1'b1;
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = 5'd8;
    bus.tbl_data = 8'd50;
    tick();
    rst          = 1'b0;
    bus.tbl_we   = 1'b0;
    bus.in_valid = 1'b0;
    tblModel     = tblDefaults;
    #1;
    compareCount++;
    if ({bus.in_ready, snap()} !== {1'b1, 33'd0}) begin
      failCount++;
      $display("[TB] FAIL midreset_clear: got %h expected %h", {bus.in_ready, snap()}, {1'b1, 33'd0});
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      compareCount++;
      if (bus.out_valid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL midreset_stale cycle %0d: out_valid got %b expected 0", k, bus.out_valid);
      end
    end
    driveLookup(8'h00);
    compareCount++;
    if (snap() !== {1'b1, 8'd8, 8'd12, 8'd4, 8'd0}) begin
      failCount++;
      $display("[TB] FAIL midreset_table_restored: got %h expected %h", snap(), {1'b1, 8'd8, 8'd12, 8'd4, 8'd0});
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    compareCount  = 0;
    failCount     = 0;
    rst           = 1'b1;
    bus.x         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_data  = '0;
    test_reset();
    test_lookup();
    test_random();
    test_stall();
    test_table_write();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/sigmoid_lut_fetch.md
SIGMOID_LUT_FETCH -- requirements
Module: sigmoid_lut_fetch

Interface
REQ-001 Parameter DW, 8, data width of all signed sample ports.
REQ-002 Parameter FRAC, 4, fractional bits of the input; also the interpolator shift.
REQ-003 Parameter NSEG, 16, number of table segments; the table holds NSEG+1 entries.
REQ-004 Port clk input 1: single clock; all state updates on rising edge.
REQ-005 Port rst input 1: reset, synchronous, active-high.
REQ-006 Port x input DW: signed Q3.4 operand to be looked up.
REQ-007 Port in_valid input 1 / in_ready output 1: input handshake.
REQ-008 Port base output DW: signed table value at segment start.
REQ-009 Port next__data output DW: signed table value at segment end.
REQ-010 Port change output DW: next__data minus base, signed.
REQ-011 Port remaining output DW: fractional position in segment, 0..15, zero-extended.
REQ-012 Port out_valid output 1 / out_ready input 1: output handshake toward the interpolator.
REQ-013 Port tbl_we input 1, tbl_addr input 5, tbl_data input DW: runtime table write port.

Function
REQ-014 The block shall split x into idx = (x >>> FRAC) + NSEG/2 (range 0..15) and rem = x[FRAC-1:0].
REQ-015 Stage 1 shall register idx, rem and v1 on each advance; stage 2 shall register base = T[idx], next__data = T[idx+1], change, remaining and v2 on each advance.
REQ-016 advance = !v2 | out_ready; in_ready shall equal advance combinationally; a transfer occurs when in_valid & in_ready.
REQ-017 Latency shall be exactly 2 cycles from accepted input to out_valid with no stall; throughput shall be 1 sample per cycle.
REQ-018 When advance is 0, both stages and all outputs shall hold unchanged; no sample shall be dropped or duplicated.
REQ-019 When advance is 1 and in_valid is 0, v1 shall load 0 (bubble), and stage 2 shall take v1's old value.
REQ-020 change shall be computed as a DW-bit wrapping subtraction; default table values never wrap.
REQ-021 Table T shall be 17 DW-bit registers; T[NSEG] is the saturation endpoint, so idx+1 never exceeds 16.
REQ-022 When tbl_we is 1 and tbl_addr <= 16, T[tbl_addr] shall take tbl_data at the clock edge; addresses 17..31 shall be ignored.
REQ-023 A stage-2 read in the same cycle as a write to the same address shall return the old value; the new value shall be used from the next cycle.
REQ-024 Table writes shall not stall or affect the handshake.

Reset
REQ-025 On rst, v1, v2, out_valid, base, next__data, change and remaining shall be 0.
REQ-026 On rst, T shall reload the sigmoid defaults 0,0,0,0,0,1,2,4,8,12,14,15,16,16,16,16,16 for indices 0..16.
REQ-027 rst mid-stream shall discard all in-flight samples, and in_ready shall be 1 in the first cycle after reset.
REQ-028 rst shall take priority over tbl_we in the same cycle.

Structure
REQ-029 A shared package shall hold DW, FRAC, NSEG, the table depth, and the default sigmoid table constant.
REQ-030 The block shall contain one sub-module, sigmoid_lut_table, holding the 17-entry register file with its write port and two combinational read ports.
REQ-031 Outputs shall connect directly to the downstream interpolator inputs of the same names.

Verification
REQ-032 After reset, x=0x00 -> 2 cycles later: out_valid=1, base=8, next__data=12, change=4, remaining=0.
REQ-033 x=0x18 (1.5) -> base=12, next__data=14, change=2, remaining=8; x=0x80 -> base=0, next__data=0, remaining=0; x=0x7F -> base=16, next__data=16, change=0, remaining=15.
REQ-034 Stream x=0x00,0x10,0x20 with out_ready held 0 for 3 cycles after the first output -> in_ready=0 while stalled, outputs hold, then 8/12/14 bases are emitted in order with none lost.
REQ-035 Write tbl_addr=8, tbl_data=10, then x=0x00 -> base=10, change=2; write tbl_addr=20 -> table unchanged.
REQ-036 Assert rst with 2 samples in flight -> out_valid=0 next cycle, all outputs 0, T[8]=8 restored, and no stale sample emitted afterwards.
